// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared FSM encodings, header map and stride for the matmul sequencer
package matmul_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_RD_A  = 3'd3;
    localparam logic [2:0] S_RD_B  = 3'd4;
    localparam logic [2:0] S_MAC   = 3'd5;
    localparam logic [2:0] S_WR    = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam int DFLT_HDR_M_ADDR = 0;
    localparam int DFLT_HDR_N_ADDR = 2;
    localparam int DFLT_HDR_L_ADDR = 4;
    localparam int DFLT_HDR_A_ADDR = 12;
    localparam int DFLT_HDR_C_ADDR = 14;

    localparam int ELEM_STRIDE = 2;
    // Five header reads issued on cycles 0-4, last capture on cycle 5.
    localparam int HDR_CYCLES  = 6;

endpackage

// File: rtl/matmul_mac.sv
// rtl/matmul_mac.sv - unsigned multiply-accumulate register wrapping at twice the operand width
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      en,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic [2*DATA_WIDTH-1:0]   acc
);

    localparam int RW = 2 * DATA_WIDTH;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + RW'(a) * RW'(b);
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - header fetch, i/j/k loop sequencing and C write-back over a single-port byte memory
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int HDR_M_ADDR = DFLT_HDR_M_ADDR,
    parameter int HDR_N_ADDR = DFLT_HDR_N_ADDR,
    parameter int HDR_L_ADDR = DFLT_HDR_L_ADDR,
    parameter int HDR_A_ADDR = DFLT_HDR_A_ADDR,
    parameter int HDR_C_ADDR = DFLT_HDR_C_ADDR
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_w_addr,
    output logic [2*DATA_WIDTH-1:0]   mem_w_data,
    output logic [ADDR_WIDTH-1:0]     mem_r_addr,
    input  logic [DATA_WIDTH-1:0]     mem_r_data
);

    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int RW = 2 * DATA_WIDTH;
    localparam logic [AW-1:0] STRIDE = AW'(ELEM_STRIDE);

    logic [2:0]    state;
    logic [2:0]    hdr_cnt;
    logic [DW-1:0] m_dim, n_dim, l_dim;
    logic [DW-1:0] i_cnt, j_cnt, k_cnt;
    logic [DW-1:0] a_val;
    logic [AW-1:0] a_base, b_base, c_base;
    logic [AW-1:0] a_addr, b_addr, c_addr;
    logic [RW-1:0] acc;
    logic          last_i, last_j, last_k;
    logic          mac_clear, mac_en;

    function automatic logic [AW-1:0] to_addr(input logic [DW-1:0] v);
        return AW'(v);
    endfunction

    function automatic logic [AW-1:0] hdr_rd_addr(input logic [2:0] idx);
        case (idx)
            3'd0:    return AW'(HDR_M_ADDR);
            3'd1:    return AW'(HDR_N_ADDR);
            3'd2:    return AW'(HDR_L_ADDR);
            3'd3:    return AW'(HDR_A_ADDR);
            3'd4:    return AW'(HDR_C_ADDR);
            default: return '0;
        endcase
    endfunction

    // All address arithmetic is deliberately truncated to AW bits so it wraps.
    assign a_addr = a_base + STRIDE * (to_addr(i_cnt) * to_addr(n_dim) + to_addr(k_cnt));
    assign b_addr = b_base + STRIDE * (to_addr(k_cnt) * to_addr(l_dim) + to_addr(j_cnt));
    assign c_addr = c_base + STRIDE * (to_addr(i_cnt) * to_addr(l_dim) + to_addr(j_cnt));

    assign last_i = (i_cnt == m_dim - DW'(1));
    assign last_j = (j_cnt == l_dim - DW'(1));
    assign last_k = (k_cnt == n_dim - DW'(1));

    assign mac_clear = (state == S_SETUP) || (state == S_WR);
    assign mac_en    = (state == S_MAC);

    matmul_mac #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clear (mac_clear),
        .en    (mac_en),
        .a     (a_val),
        .b     (mem_r_data),
        .acc   (acc)
    );

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        mem_we     = 1'b0;
        mem_w_addr = '0;
        mem_w_data = '0;
        mem_r_addr = '0;
        case (state)
            S_HDR: begin
                busy       = 1'b1;
                mem_r_addr = hdr_rd_addr(hdr_cnt);
            end
            S_SETUP: busy = 1'b1;
            S_RD_A: begin
                busy       = 1'b1;
                mem_r_addr = a_addr;
            end
            S_RD_B: begin
                busy       = 1'b1;
                mem_r_addr = b_addr;
            end
            S_MAC: busy = 1'b1;
            S_WR: begin
                busy       = 1'b1;
                mem_we     = 1'b1;
                mem_w_addr = c_addr;
                mem_w_data = acc;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            hdr_cnt <= '0;
            m_dim   <= '0;
            n_dim   <= '0;
            l_dim   <= '0;
            i_cnt   <= '0;
            j_cnt   <= '0;
            k_cnt   <= '0;
            a_val   <= '0;
            a_base  <= '0;
            b_base  <= '0;
            c_base  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_HDR;
                        hdr_cnt <= '0;
                    end
                end
                S_HDR: begin
                    // Data for the read issued on cycle h arrives on cycle h+1.
                    case (hdr_cnt)
                        3'd1:    m_dim  <= mem_r_data;
                        3'd2:    n_dim  <= mem_r_data;
                        3'd3:    l_dim  <= mem_r_data;
                        3'd4:    a_base <= AW'(mem_r_data);
                        3'd5:    c_base <= AW'(mem_r_data);
                        default: ;
                    endcase
                    if (hdr_cnt == 3'(HDR_CYCLES - 1)) begin
                        hdr_cnt <= '0;
                        state   <= S_SETUP;
                    end else begin
                        hdr_cnt <= hdr_cnt + 3'd1;
                    end
                end
                S_SETUP: begin
                    b_base <= a_base + STRIDE * to_addr(m_dim) * to_addr(n_dim);
                    i_cnt  <= '0;
                    j_cnt  <= '0;
                    k_cnt  <= '0;
                    if (m_dim == '0 || n_dim == '0 || l_dim == '0) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_RD_A;
                    end
                end
                S_RD_A: state <= S_RD_B;
                S_RD_B: begin
                    a_val <= mem_r_data;
                    state <= S_MAC;
                end
                S_MAC: begin
                    if (last_k) begin
                        state <= S_WR;
                    end else begin
                        k_cnt <= k_cnt + DW'(1);
                        state <= S_RD_A;
                    end
                end
                S_WR: begin
                    k_cnt <= '0;
                    if (last_j) begin
                        j_cnt <= '0;
                        i_cnt <= i_cnt + DW'(1);
                    end else begin
                        j_cnt <= j_cnt + DW'(1);
                    end
                    state <= (last_i && last_j) ? S_DONE : S_RD_A;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb/tb_matmul_seq_ctrl.sv - directed self-checking bench for matmul_seq_ctrl with a byte memory model
module tb_matmul_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, mem_we;
    logic [7:0]  mem_w_addr, mem_r_addr;
    logic [7:0]  mem_r_data;
    logic [15:0] mem_w_data;

    logic [7:0]  mem [256];
    logic        tb_wr = 1'b0;
    logic        tb_clr = 1'b0;
    logic [7:0]  tb_addr = 8'd0;
    logic [7:0]  tb_data = 8'd0;
    int          wr_addr_q[$];
    int          wr_data_q[$];

    int tests_run = 0;
    int failed = 0;

    int r_done_cyc, r_n_done, r_n_we, r_we_at_rst, r_busy_after, r_we_after, r_bad_rd;

    always #5 clk = ~clk;

    matmul_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_we     (mem_we),
        .mem_w_addr (mem_w_addr),
        .mem_w_data (mem_w_data),
        .mem_r_addr (mem_r_addr),
        .mem_r_data (mem_r_data)
    );

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int a = 0; a < 256; a++) mem[a] <= 8'h00;
        end else if (tb_wr) begin
            mem[tb_addr] <= tb_data;
        end else if (mem_we) begin
            mem[mem_w_addr]         <= mem_w_data[7:0];
            mem[mem_w_addr + 8'd1]  <= mem_w_data[15:8];
            wr_addr_q.push_back(int'(mem_w_addr));
            wr_data_q.push_back(int'(mem_w_data));
        end
        if (!mem_we) mem_r_data <= mem[mem_r_addr];
    end

    task automatic poke(input int a, input int d);
        tb_wr   = 1'b1;
        tb_addr = 8'(a);
        tb_data = 8'(d);
        @(negedge clk);
        tb_wr = 1'b0;
    endtask

    task automatic clear_mem();
        tb_clr = 1'b1;
        @(negedge clk);
        tb_clr = 1'b0;
    endtask

    task automatic load_hdr(input int m, input int n, input int l, input int ab, input int cb);
        poke(0, m);
        poke(2, n);
        poke(4, l);
        poke(12, ab);
        poke(14, cb);
        poke(6, 8'hAA);
        poke(8, 8'hAA);
        poke(10, 8'hAA);
    endtask

    task automatic setup_basic();
        clear_mem();
        load_hdr(2, 3, 2, 16, 70);
        for (int e = 0; e < 6; e++) begin
            poke(16 + 2 * e, 1 + e);
            poke(28 + 2 * e, 7 + e);
        end
    endtask

    // Pulses start, then observes every cycle until 5 cycles past done or the budget expires.
    task automatic run_op(input int restart_at, input int reset_at, input int budget);
        r_done_cyc = -1; r_n_done = 0; r_n_we = 0; r_we_at_rst = -1;
        r_busy_after = -1; r_we_after = -1; r_bad_rd = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            start = (cyc == restart_at);
            reset = (cyc == reset_at);
            if (cyc == reset_at) r_we_at_rst = int'(mem_we);
            if (reset_at > 0 && cyc == reset_at + 1) begin
                r_busy_after = int'(busy);
                r_we_after   = int'(mem_we);
            end
            if (done) begin
                r_n_done++;
                if (r_done_cyc < 0) r_done_cyc = cyc;
            end
            if (mem_we) r_n_we++;
            if (busy && (mem_r_addr == 8'd6 || mem_r_addr == 8'd8 || mem_r_addr == 8'd10)) r_bad_rd++;
            if (r_done_cyc >= 0 && cyc >= r_done_cyc + 5) break;
            @(negedge clk);
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %0b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done got %0b want 0", done); end
        tests_run++; if (mem_we !== 1'b0) begin failed++; $display("FAIL reset_we got %0b want 0", mem_we); end
        tests_run++; if (mem_r_addr !== 8'd0) begin failed++; $display("FAIL reset_raddr got %0d want 0", mem_r_addr); end
        tests_run++; if (mem_w_addr !== 8'd0) begin failed++; $display("FAIL reset_waddr got %0d want 0", mem_w_addr); end
        tests_run++; if (mem_w_data !== 16'd0) begin failed++; $display("FAIL reset_wdata got %0d want 0", mem_w_data); end
        reset = 1'b0;
        clear_mem();
        repeat (2) @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL idle_busy got %0b want 0", busy); end
    endtask

    task automatic check_basic_writes(input string tag, input int base);
        int exp_a[4] = '{70, 72, 74, 76};
        int exp_d[4] = '{58, 64, 139, 154};
        tests_run++;
        if (wr_addr_q.size() - base !== 4) begin
            failed++; $display("FAIL %s_wr_count got %0d want 4", tag, wr_addr_q.size() - base);
        end
        for (int e = 0; e < 4; e++) begin
            int ga = (base + e < wr_addr_q.size()) ? wr_addr_q[base + e] : -1;
            int gd = (base + e < wr_data_q.size()) ? wr_data_q[base + e] : -1;
            tests_run++;
            if (ga !== exp_a[e] || gd !== exp_d[e]) begin
                failed++; $display("FAIL %s_wr%0d got addr %0d data %0d want addr %0d data %0d", tag, e, ga, gd, exp_a[e], exp_d[e]);
            end
            tests_run++;
            if (mem[exp_a[e]] !== 8'(exp_d[e]) || mem[exp_a[e] + 1] !== 8'h00) begin
                failed++; $display("FAIL %s_mem%0d got lo %0d hi %0d want lo %0d hi 0", tag, e, mem[exp_a[e]], mem[exp_a[e] + 1], exp_d[e]);
            end
        end
    endtask

    task automatic test_basic();
        int base;
        setup_basic();
        base = wr_addr_q.size();
        run_op(0, 0, 200);
        tests_run++; if (r_done_cyc !== 48) begin failed++; $display("FAIL basic_latency got %0d want 48", r_done_cyc); end
        tests_run++; if (r_n_done !== 1) begin failed++; $display("FAIL basic_done_pulses got %0d want 1", r_n_done); end
        check_basic_writes("basic", base);
        tests_run++;
        if (mem[6] !== 8'hAA || mem[8] !== 8'hAA || mem[10] !== 8'hAA) begin
            failed++; $display("FAIL basic_loop_bytes got %0h %0h %0h want aa aa aa", mem[6], mem[8], mem[10]);
        end
        tests_run++; if (r_bad_rd !== 0) begin failed++; $display("FAIL basic_loop_reads got %0d want 0", r_bad_rd); end
    endtask

    task automatic test_degenerate();
        int base;
        clear_mem();
        load_hdr(2, 0, 2, 16, 70);
        base = wr_addr_q.size();
        run_op(0, 0, 100);
        tests_run++; if (r_done_cyc !== 8) begin failed++; $display("FAIL degen_latency got %0d want 8", r_done_cyc); end
        tests_run++; if (r_n_we !== 0) begin failed++; $display("FAIL degen_we got %0d want 0", r_n_we); end
        tests_run++; if (wr_addr_q.size() !== base) begin failed++; $display("FAIL degen_log got %0d want %0d", wr_addr_q.size(), base); end
    endtask

    task automatic test_acc_wrap();
        int base;
        clear_mem();
        load_hdr(1, 2, 1, 16, 40);
        poke(16, 255); poke(18, 255);
        poke(20, 255); poke(22, 255);
        base = wr_addr_q.size();
        run_op(0, 0, 100);
        tests_run++; if (r_done_cyc !== 15) begin failed++; $display("FAIL wrap_latency got %0d want 15", r_done_cyc); end
        tests_run++;
        if (wr_data_q.size() <= base || wr_data_q[base] !== 16'hFC02 || wr_addr_q[base] !== 40) begin
            failed++; $display("FAIL wrap_write got %0d entries want data 64514 at 40", wr_data_q.size() - base);
        end
        tests_run++;
        if (mem[40] !== 8'h02 || mem[41] !== 8'hFC) begin
            failed++; $display("FAIL wrap_bytes got %0h %0h want 02 fc", mem[40], mem[41]);
        end
    endtask

    task automatic test_start_busy();
        int base;
        setup_basic();
        base = wr_addr_q.size();
        run_op(10, 0, 200);
        tests_run++; if (r_done_cyc !== 48) begin failed++; $display("FAIL busy_latency got %0d want 48", r_done_cyc); end
        tests_run++; if (r_n_done !== 1) begin failed++; $display("FAIL busy_done_pulses got %0d want 1", r_n_done); end
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL busy_after got %0b want 0", busy); end
        check_basic_writes("busy", base);
    endtask

    task automatic test_reset_mid();
        int base;
        setup_basic();
        run_op(0, 27, 120);
        tests_run++; if (r_we_at_rst !== 1) begin failed++; $display("FAIL rst_in_wr got %0d want 1", r_we_at_rst); end
        tests_run++; if (r_we_after !== 0) begin failed++; $display("FAIL rst_we_after got %0d want 0", r_we_after); end
        tests_run++; if (r_busy_after !== 0) begin failed++; $display("FAIL rst_busy_after got %0d want 0", r_busy_after); end
        tests_run++; if (r_n_done !== 0) begin failed++; $display("FAIL rst_done got %0d want 0", r_n_done); end
        tests_run++; if (r_n_we !== 2) begin failed++; $display("FAIL rst_we_count got %0d want 2", r_n_we); end
        for (int a = 70; a < 78; a++) poke(a, 8'hEE);
        base = wr_addr_q.size();
        run_op(0, 0, 200);
        tests_run++; if (r_done_cyc !== 48) begin failed++; $display("FAIL rst_rerun_latency got %0d want 48", r_done_cyc); end
        check_basic_writes("rerun", base);
    endtask

    task automatic test_addr_wrap();
        int base;
        clear_mem();
        load_hdr(1, 1, 2, 16, 254);
        poke(16, 3);
        poke(18, 5);
        poke(20, 7);
        base = wr_addr_q.size();
        run_op(0, 0, 100);
        tests_run++; if (r_done_cyc !== 16) begin failed++; $display("FAIL awrap_latency got %0d want 16", r_done_cyc); end
        tests_run++;
        if (wr_addr_q.size() - base !== 2 || wr_addr_q[base] !== 254 || wr_data_q[base] !== 15
            || wr_addr_q[base + 1] !== 0 || wr_data_q[base + 1] !== 21) begin
            failed++; $display("FAIL awrap_writes got %0d entries want (254,15),(0,21)", wr_addr_q.size() - base);
        end
        tests_run++;
        if (mem[254] !== 8'd15 || mem[255] !== 8'd0 || mem[0] !== 8'd21 || mem[1] !== 8'd0) begin
            failed++; $display("FAIL awrap_bytes got %0d %0d %0d %0d want 15 0 21 0", mem[254], mem[255], mem[0], mem[1]);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_degenerate();
        test_acc_wrap();
        test_start_busy();
        test_reset_mid();
        test_addr_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired tests_run %0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencer that runs one integer matrix multiply C = A·B out of the single-port byte data memory.
- Reads the header from memory: m, n, l, A base and C base. A is m×n and B is n×l, both row-major.
- Runs a k-loop of multiply-accumulate per result element and writes each 16-bit result back through the memory's 16-bit write path.
- Sits between the top-level start/done control and the data memory. It is the only master of the memory while busy.

Parameters:
- DATA_WIDTH, 8, element/byte width. Results are 2*DATA_WIDTH bits.
- ADDR_WIDTH, 8, memory byte-address width.
- HDR_M_ADDR, 0, address of m.
- HDR_N_ADDR, 2, address of n.
- HDR_L_ADDR, 4, address of l.
- HDR_A_ADDR, 12, address of the byte holding the A base address.
- HDR_C_ADDR, 14, address of the byte holding the C base address.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request to begin a multiply.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last C element has been written.
- mem_we  out  1  memory write enable.
- mem_w_addr  out  ADDR_WIDTH  write byte address.
- mem_w_data  out  2*DATA_WIDTH  result; the low byte goes to addr, the high byte to addr+1.
- mem_r_addr  out  ADDR_WIDTH  read byte address.
- mem_r_data  in  DATA_WIDTH  registered read data, valid the cycle after the address is presented with mem_we=0.

Behaviour:
- Reset values:
  - All outputs are 0.
  - The FSM is in IDLE.
  - Counters and accumulator are 0.
  - Reset has priority in every state, including mid-write. No further memory write occurs after reset is sampled.
- start:
  - Accepted only in IDLE.
  - Ignored while busy. It is not queued.
- Read timing:
  - The read address is issued in cycle t with mem_we=0. Data is captured in cycle t+1.
  - mem_we is never high during a cycle whose read result is needed.
- FSM states:
  - IDLE: wait for start.
  - HDR: 6 cycles. Issues reads of M, N, L, A, C on cycles 0–4 and captures each on the following cycle.
  - SETUP: 1 cycle.
    - b_base = a_base + 2*m*n, computed mod 2^ADDR_WIDTH.
    - Clears i, j, k and acc.
    - If m, n or l is 0, go directly to DONE with no writes.
  - RD_A: issue mem_r_addr = a_base + 2*(i*n + k).
  - RD_B: capture a_val; issue mem_r_addr = b_base + 2*(k*l + j).
  - MAC: capture b_val; acc <= acc + a_val*b_val.
    - The product is unsigned, 2*DATA_WIDTH bits. The sum wraps mod 2^(2*DATA_WIDTH).
    - If k == n-1, go to WR. Otherwise k++ and go to RD_A.
  - WR: one cycle.
    - Drive mem_we=1, mem_w_addr = c_base + 2*(i*l + j), mem_w_data = acc.
    - Then clear acc and k, and advance j. When j wraps from l-1 to 0, advance i.
    - If i == m-1 and j == l-1, go to DONE. Otherwise go to RD_A.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Addressing:
  - Addresses are computed in ADDR_WIDTH bits and wrap silently.
  - Elements are 2-byte strided. Only the low byte of each A/B element is read.
- Latency:
  - Each result element takes 3n + 1 cycles.
  - Total from start accepted = 1 + 6 + 1 + m*l*(3n+1) cycles to the done pulse.
- Memory side effects:
  - The loop bytes at addresses 6, 8 and 10 are neither read nor written.
  - C writes overwrite any prior contents.

Decomposition:
- Shared package matmul_pkg:
  - FSM state enum (IDLE, HDR, SETUP, RD_A, RD_B, MAC, WR, DONE).
  - Header address constants.
  - ELEM_STRIDE = 2.
- One natural sub-module: matmul_mac. It holds the accumulator register and has clear/enable inputs and DATA_WIDTH operands.
- Address arithmetic and counters stay in the controller.

Test Plan:
1. Basic 2×3×2 multiply.
   - Stimulus: preload m=2, n=3, l=2, A base=16, C base=70; A=1..6 at 16..26; B=7..12 at 28..38; pulse start.
   - Required: writes of 58, 64, 139, 154 at addresses 70, 72, 74, 76, in that order; done on cycle 8 + 4*10 = 48 after start; bytes 71, 73, 75, 77 = 0.
2. Degenerate dimension.
   - Stimulus: n=0 with m=2, l=2.
   - Required: no mem_we pulses; done exactly 8 cycles after start.
3. Accumulator wrap.
   - Stimulus: m=n=l=1 is not enough to wrap, so use m=1, n=2, l=1 with A=B=255.
   - Required: C = 2*65025 mod 65536 = 64514 (0xFC02); the 16-bit write puts 0x02 at C and 0xFC at C+1.
4. start while busy.
   - Stimulus: pulse start again mid-MAC.
   - Required: no restart, results identical to scenario 1, a single done pulse.
5. Reset mid-operation.
   - Stimulus: assert reset during the second WR.
   - Required: mem_we=0 from the next cycle, busy=0, done never pulses; a following start reruns the multiply and produces the correct C.
6. Address wrap.
   - Stimulus: C base = 254 with m=1, l=2.
   - Required: the second result is written at address 0 (wraps mod 256).
